// File: rtl/icb_sram_slave_pkg.sv
// rtl/icb_sram_slave_pkg.sv - shared bus widths, SRAM defaults, response type and address check
package icb_sram_slave_pkg;

  // Bus geometry of the core memory port
  localparam int MEM_BUS_W  = 32;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_MASK_W = MEM_BUS_W / 8;

  // Default placement and sizing of the data SRAM
  localparam logic [MEM_ADDR_W-1:0] SRAM_BASE_ADDR   = 32'h2000_0000;
  localparam int                    SRAM_DEPTH_WORDS = 4096;
  localparam int                    SRAM_RSP_DEPTH   = 4;

  // One queued response: error flag plus read data
  typedef struct packed {
    logic                 err;
    logic [MEM_BUS_W-1:0] rdata;
  } icb_rsp_t;

  localparam int RSP_W = $bits(icb_rsp_t);

  // Word-aligned and inside [base, base + span); span is in bytes
  function automatic logic icb_addr_legal(input logic [MEM_ADDR_W-1:0] addr,
                                          input logic [MEM_ADDR_W-1:0] base,
                                          input logic [MEM_ADDR_W-1:0] span);
    logic [MEM_ADDR_W-1:0] off;
    off = addr - base;
    return (addr >= base) && (off < span) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/icb_sram_slave_if.sv
// rtl/icb_sram_slave_if.sv - ICB command/response bundle with master and slave views
interface icb_sram_slave_if;
  import icb_sram_slave_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [MEM_ADDR_W-1:0] cmd_addr;
  logic                  cmd_read;
  logic [MEM_BUS_W-1:0]  cmd_wdata;
  logic [MEM_MASK_W-1:0] cmd_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_err;
  logic [MEM_BUS_W-1:0]  rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/icb_rsp_fifo.sv
// rtl/icb_rsp_fifo.sv - synchronous response FIFO with occupancy count
module icb_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO is only taken when the head leaves the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage, pointers and occupancy; storage is cleared so the head is never X
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/icb_sram_slave.sv
// rtl/icb_sram_slave.sv - ICB responder in front of a byte-masked single-port data SRAM
module icb_sram_slave
  import icb_sram_slave_pkg::*;
#(
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = SRAM_BASE_ADDR,
  parameter int                    DEPTH_WORDS = SRAM_DEPTH_WORDS,
  parameter int                    RSP_DEPTH   = SRAM_RSP_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  icb_sram_slave_if.slave  sram_icb
);

  localparam int                    IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [MEM_ADDR_W-1:0] SPAN_BYTES = MEM_ADDR_W'(DEPTH_WORDS) << 2;
  localparam int                    CNT_W      = $clog2(RSP_DEPTH + 1);
  localparam int                    CRD_W      = $clog2(RSP_DEPTH + 2);

  // Command acceptance
  logic             cmd_fire;
  logic             cmd_legal;
  logic [IDX_W-1:0] cmd_idx;

  // SRAM array, four byte lanes per word, and its registered read port
  logic [MEM_MASK_W-1:0][7:0] mem [DEPTH_WORDS];
  logic [MEM_BUS_W-1:0]       sram_q;

  // Access stage: one accepted command whose response is being formed
  logic s1_valid;
  logic s1_err;
  logic s1_read;

  // Response queue
  icb_rsp_t         s1_rsp;
  logic [RSP_W-1:0] head_bits;
  icb_rsp_t         head_rsp;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CRD_W-1:0] credits;

  // Every command in S1 or in the FIFO owns a FIFO slot, so accepting only
  // while credits remain means the FIFO can never overflow. Ready looks only
  // at registered state, never at cmd_valid or rsp_ready.
  assign credits            = CRD_W'(s1_valid) + CRD_W'(fifo_count);
  assign sram_icb.cmd_ready = rst_n & (credits < CRD_W'(RSP_DEPTH));
  assign cmd_fire           = sram_icb.cmd_valid & sram_icb.cmd_ready;

  assign cmd_legal = icb_addr_legal(sram_icb.cmd_addr, BASE_ADDR, SPAN_BYTES);
  assign cmd_idx   = IDX_W'((sram_icb.cmd_addr - BASE_ADDR) >> 2);

  // SRAM port: masked write or read-first read, only for legal accepted commands.
  // The array is not reset, so writes accepted before a reset survive it.
  always_ff @(posedge clk) begin
    if (cmd_fire && cmd_legal) begin
      if (sram_icb.cmd_read) begin
        sram_q <= mem[cmd_idx];
      end else begin
        for (int i = 0; i < MEM_MASK_W; i++) begin
          if (sram_icb.cmd_wmask[i]) begin
            mem[cmd_idx][i] <= sram_icb.cmd_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Access stage register: tracks what kind of response the SRAM cycle produces
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_read  <= 1'b0;
    end else begin
      s1_valid <= cmd_fire;
      if (cmd_fire) begin
        s1_err  <= ~cmd_legal;
        s1_read <= sram_icb.cmd_read;
      end
    end
  end

  // Writes and rejected commands answer with zero data; legal reads return the word
  always_comb begin
    s1_rsp.err   = s1_err;
    s1_rsp.rdata = (s1_read && !s1_err) ? sram_q : '0;
  end

  assign fifo_pop  = ~fifo_empty & sram_icb.rsp_ready;
  assign fifo_push = s1_valid & (~fifo_full | fifo_pop);

  icb_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (s1_rsp),
    .pop       (fifo_pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Response fields come straight from the FIFO head and are held at zero when idle
  assign head_rsp           = icb_rsp_t'(head_bits);
  assign sram_icb.rsp_valid = ~fifo_empty;
  assign sram_icb.rsp_err   = head_rsp.err & ~fifo_empty;
  assign sram_icb.rsp_rdata = fifo_empty ? '0 : head_rsp.rdata;

endmodule

// File: tb/tb_icb_sram_slave.sv
// tb/tb_icb_sram_slave.sv - directed self-checking bench for icb_sram_slave
module tb_icb_sram_slave;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  icb_sram_slave_if sram_icb ();

  icb_sram_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sram_icb (sram_icb)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          acc_log[$];
  int          rsp_cyc[$];
  logic [32:0] rsp_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are recorded half a cycle before the edge that completes them
  always @(negedge clk) begin
    if (sram_icb.cmd_valid && sram_icb.cmd_ready) acc_log.push_back(cyc);
    if (sram_icb.rsp_valid && sram_icb.rsp_ready) begin
      rsp_log.push_back({sram_icb.rsp_err, sram_icb.rsp_rdata});
      rsp_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    rsp_log.delete();
    rsp_cyc.delete();
  endtask

  task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    bit ok;
    ok = 1'b0;
    sram_icb.cmd_valid = 1'b1;
    sram_icb.cmd_read  = rd;
    sram_icb.cmd_addr  = a;
    sram_icb.cmd_wdata = wd;
    sram_icb.cmd_wmask = m;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = sram_icb.cmd_ready;
      step();
    end
    sram_icb.cmd_valid = 1'b0;
    chk("cmd_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsp(input string tag, input int n);
    for (int i = 0; i < 100 && rsp_log.size() < n; i++) step();
    chk(tag, 64'(rsp_log.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] exp_ill [7];

    rst_n              = 1'b0;
    sram_icb.cmd_valid = 1'b0;
    sram_icb.cmd_read  = 1'b0;
    sram_icb.cmd_addr  = '0;
    sram_icb.cmd_wdata = '0;
    sram_icb.cmd_wmask = '0;
    sram_icb.rsp_ready = 1'b0;

    // Reset values
    step();
    step();
    @(negedge clk);
    chk("rst_cmd_ready", 64'(sram_icb.cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(sram_icb.rsp_valid), 64'd0);
    chk("rst_rsp_err",   64'(sram_icb.rsp_err),   64'd0);
    chk("rst_rsp_rdata", 64'(sram_icb.rsp_rdata), 64'd0);
    step();
    rst_n              = 1'b1;
    sram_icb.rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(sram_icb.cmd_ready), 64'd1);
    chk("post_rst_rsp_valid", 64'(sram_icb.rsp_valid), 64'd0);
    step();

    // Write then read back, with latency
    clear_logs();
    send(1'b0, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF);
    send(1'b1, 32'h2000_0010, 32'h0, 4'h0);
    wait_rsp("wr_rd_count", 2);
    chk("wr_rsp", 64'(rsp_log[0]), 64'({1'b0, 32'h0}));
    chk("rd_rsp", 64'(rsp_log[1]), 64'({1'b0, 32'hDEAD_BEEF}));
    chk("first_rsp_latency", 64'(rsp_cyc[0] - acc_log[0]), 64'd2);
    chk("back_to_back_accept", 64'(acc_log[1] - acc_log[0]), 64'd1);

    // Byte masks, read-after-write, and an all-zero mask
    clear_logs();
    send(1'b0, 32'h2000_0010, 32'h0000_0011, 4'b0001);
    send(1'b0, 32'h2000_0010, 32'h0000_2200, 4'b0010);
    send(1'b1, 32'h2000_0010, 32'h0, 4'h0);
    send(1'b0, 32'h2000_0010, 32'hFFFF_FFFF, 4'b0000);
    send(1'b1, 32'h2000_0010, 32'h0, 4'h0);
    wait_rsp("mask_count", 5);
    chk("mask_rd", 64'(rsp_log[2]), 64'({1'b0, 32'hDEAD_2211}));
    chk("mask0_wr_rsp", 64'(rsp_log[3]), 64'({1'b0, 32'h0}));
    chk("mask0_rd", 64'(rsp_log[4]), 64'({1'b0, 32'hDEAD_2211}));

    // Illegal addresses and the last legal word
    clear_logs();
    send(1'b0, 32'h2000_0000, 32'h1234_5678, 4'hF);
    send(1'b1, 32'h1FFF_FFFC, 32'h0, 4'h0);
    send(1'b1, 32'h2000_4000, 32'h0, 4'h0);
    send(1'b0, 32'h2000_0002, 32'hFFFF_FFFF, 4'hF);
    send(1'b1, 32'h2000_0000, 32'h0, 4'h0);
    send(1'b0, 32'h2000_3FFC, 32'hCAFE_F00D, 4'hF);
    send(1'b1, 32'h2000_3FFC, 32'h0, 4'h0);
    wait_rsp("illegal_count", 7);
    exp_ill = '{{1'b0, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0},
                {1'b0, 32'h1234_5678}, {1'b0, 32'h0}, {1'b0, 32'hCAFE_F00D}};
    for (int i = 0; i < 7; i++) chk($sformatf("illegal_rsp_%0d", i), 64'(rsp_log[i]), 64'(exp_ill[i]));

    // Prefill a block of words for the read tests
    clear_logs();
    for (int i = 0; i < 16; i++) send(1'b0, 32'h2000_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF);
    wait_rsp("prefill_count", 16);

    // Backpressure: four accepted, fifth stalls until a response pops
    clear_logs();
    sram_icb.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, 32'h2000_0100 + 32'(4 * i), 32'h0, 4'h0);
    sram_icb.cmd_valid = 1'b1;
    sram_icb.cmd_read  = 1'b1;
    sram_icb.cmd_addr  = 32'h2000_0110;
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    chk("bp_cmd_ready", 64'(sram_icb.cmd_ready), 64'd0);
    chk("bp_accepted", 64'(acc_log.size()), 64'd4);
    chk("bp_rsp_valid", 64'(sram_icb.rsp_valid), 64'd1);
    chk("bp_head_rdata", 64'(sram_icb.rsp_rdata), 64'h0000_0000_C0DE_0000);
    step();
    sram_icb.rsp_ready = 1'b1;
    send(1'b1, 32'h2000_0110, 32'h0, 4'h0);
    send(1'b1, 32'h2000_0114, 32'h0, 4'h0);
    wait_rsp("bp_count", 6);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_rsp_%0d", i), 64'(rsp_log[i]), 64'({1'b0, 32'hC0DE_0000 + 32'(i)}));
    chk("bp_credit_release", 64'(acc_log[4] - rsp_cyc[0]), 64'd1);

    // Streaming reads at full rate
    clear_logs();
    for (int i = 0; i < 16; i++) send(1'b1, 32'h2000_0100 + 32'(4 * i), 32'h0, 4'h0);
    wait_rsp("stream_count", 16);
    chk("stream_accept_span", 64'(acc_log[15] - acc_log[0]), 64'd15);
    chk("stream_rsp_span", 64'(rsp_cyc[15] - rsp_cyc[0]), 64'd15);
    chk("stream_fill", 64'(rsp_cyc[0] - acc_log[0]), 64'd2);
    for (int i = 0; i < 16; i++) chk($sformatf("stream_rsp_%0d", i), 64'(rsp_log[i]), 64'({1'b0, 32'hC0DE_0000 + 32'(i)}));

    // Reset with three commands outstanding
    clear_logs();
    sram_icb.rsp_ready = 1'b0;
    send(1'b0, 32'h2000_0020, 32'h600D_F00D, 4'hF);
    send(1'b1, 32'h2000_0100, 32'h0, 4'h0);
    send(1'b1, 32'h2000_0104, 32'h0, 4'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready", 64'(sram_icb.cmd_ready), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", 64'(sram_icb.rsp_valid), 64'd0);
    chk("midrst_cmd_ready_after", 64'(sram_icb.cmd_ready), 64'd1);
    step();
    sram_icb.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("midrst_no_stale", 64'(rsp_log.size()), 64'd0);
    send(1'b1, 32'h2000_0020, 32'h0, 4'h0);
    wait_rsp("midrst_count", 1);
    chk("midrst_readback", 64'(rsp_log[0]), 64'({1'b0, 32'h600D_F00D}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
